move_scheduler: RTL and testbench
=================================

// Module: move_scheduler
// PURPOSE
//  Sequences move commands into Game_Logic: latches debounced LEFT/RIGHT/DOWN pulses and the gravity frame tick,
//  arbitrates them, and issues at most CMDS_PER_FRAME commands per video frame, only inside vertical blanking,
//  over a valid/ready handshake. Sits between the ButtonModule debouncers / frame counter and Game_Logic in xvga.
// PARAMETERS
//  CMDS_PER_FRAME  2   max commands accepted per blanking window (1..7)
//  HOLDOFF_CYC     4   idle vclk cycles forced after each accepted command (1..15)
//  REPEAT_FRAMES   6   frames DOWN must stay high per auto-repeat soft drop (SOFT_DROP_REPEAT_EN only)
// PORTS
//  vclk         in   1  50 MHz pixel clock; all logic on rising edge
//  rst          in   1  synchronous, active-high reset
//  frz          in   1  freeze: blocks issue and gravity capture
//  frame        in   1  1-cycle gravity tick
//  vblank_start in   1  1-cycle pulse at first blanking line (vcount==600 at line start)
//  in_vblank    in   1  level, high while vcount>=600
//  left_p       in   1  1-cycle debounced LEFT pulse
//  right_p      in   1  1-cycle debounced RIGHT pulse
//  down_p       in   1  1-cycle debounced DOWN pulse
//  down_lvl     in   1  debounced DOWN level (used only with SOFT_DROP_REPEAT_EN)
//  cmd_ready    in   1  Game_Logic accepts cmd this cycle
//  cmd_valid    out  1  command offered
//  cmd_op       out  2  00 GRAVITY_DOWN, 01 LEFT, 10 RIGHT, 11 SOFT_DOWN
//  coalesced    out  8  saturating count of requests merged into an already-pending request
// BEHAVIOUR
//  - Reset (rst high at vclk edge): cmd_valid=0, cmd_op=00, coalesced=0, all pending bits 0, frame budget=0, state IDLE.
//  - Pending bits pG,pL,pR,pD: set on frame (only if !frz), left_p, right_p, down_p; cleared when their command is accepted.
//    Pulse while bit already set (and not cleared same cycle) -> coalesced+1, saturates at 255. Set+clear same cycle -> bit stays set.
//  - Budget loads CMDS_PER_FRAME on vblank_start; decrements per accepted command; not cleared when in_vblank falls.
//  - FSM: IDLE -> ARB when any pending & in_vblank & !frz & budget>0.
//    ARB (1 cycle): choose op, register cmd_op, -> ISSUE with cmd_valid=1 next cycle.
//    ISSUE: hold cmd_valid and cmd_op stable until cmd_ready; stays valid even if in_vblank falls or frz rises.
//    On valid&ready: clear chosen bit(s), budget-1, cmd_valid=0 next cycle, -> HOLDOFF.
//    HOLDOFF: count HOLDOFF_CYC cycles, then -> IDLE.
//  - Arbitration in ARB: pG highest. If pG and pD both set -> single GRAVITY_DOWN clearing both (merge, no coalesced bump).
//    Else round robin among pL,pR,pD starting after last granted of those three; reset pointer points at LEFT first.
//  - left_p and right_p both pending: round robin decides; neither dropped.
//  - Latency: request pulse in window with FSM idle -> cmd_valid high 2 cycles later.
//  - rst mid-handshake: cmd_valid drops next edge; in-flight command is lost, no partial state retained.
//  - frz: pending L/R/D bits retained; frame pulses ignored; issue resumes when frz falls inside a window with budget.
// CONFIGURATION
//  SOFT_DROP_REPEAT_EN defined: frame-counter counts vblank_start while down_lvl=1; on reaching REPEAT_FRAMES sets pD
//    (counts as a pulse for coalescing) and restarts; counter clears when down_lvl=0 or rst.
//  Not defined: down_lvl ignored, no repeat counter logic; DOWN only via down_p.
// TESTING
//  1 rst 3 cycles, then idle -> cmd_valid=0, cmd_op=00, coalesced=0 for 1000 cycles.
//  2 left_p at vcount 610, cmd_ready tied 1 -> cmd_valid=1,op=01 exactly 2 cycles later, for 1 cycle; next cmd >= HOLDOFF_CYC+2 later.
//  3 left_p,right_p,down_p,frame all outside vblank -> frame 1: GRAVITY_DOWN(merges pD) then LEFT; frame 2: RIGHT; nothing else.
//  4 cmd_ready held 0 across in_vblank falling -> cmd_valid,cmd_op stable until ready, then single accept, budget 1 left.
//  5 left_p x300 while frz=1 -> coalesced=255 (saturated), one LEFT issued after frz falls in next window.
//  6 SOFT_DROP_REPEAT_EN, down_lvl=1 for 13 frames, REPEAT_FRAMES=6 -> exactly 2 SOFT_DOWN commands; macro off -> 0.

Source files
------------

// File: rtl/move_scheduler_if.sv
// Command handshake between move_scheduler (master) and Game_Logic (slave).
interface move_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/move_scheduler.sv
// Latches move/gravity requests, arbitrates them and issues a bounded number per vertical blanking.
// Optional feature: define SOFT_DROP_REPEAT_EN for auto-repeat soft drop while DOWN is held.
module move_scheduler #(
  parameter int unsigned CMDS_PER_FRAME = 2,
  parameter int unsigned HOLDOFF_CYC    = 4,
  parameter int unsigned REPEAT_FRAMES  = 6
) (
  input  logic               vclk,
  input  logic               rst,
  input  logic               frz,
  input  logic               frame,
  input  logic               vblank_start,
  input  logic               in_vblank,
  input  logic               left_p,
  input  logic               right_p,
  input  logic               down_p,
  input  logic               down_lvl,
  move_scheduler_if.master   cmd,
  output logic [7:0]         coalesced
);

  typedef enum logic [1:0] {StIdle, StArb, StIssue, StHoldoff} state_e;

  // Pending bit order: 0 gravity, 1 left, 2 right, 3 down.
  localparam int unsigned BitG = 0;
  localparam int unsigned BitD = 3;

  state_e      state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  rr_last_q, rr_last_d;
  logic [2:0]  budget_q, budget_d;
  logic [3:0]  hold_q, hold_d;
  logic [7:0]  coal_q, coal_d;
  logic        rep_hit;
  logic        accept;
  logic [3:0]  set_req, clr_req, bump;
  logic [2:0]  bump_cnt;
  logic [8:0]  coal_sum;
  logic        rr_any;
  logic [1:0]  rr_pick;

`ifdef SOFT_DROP_REPEAT_EN
  logic [7:0] rep_q, rep_d;

  always_comb begin
    rep_d   = rep_q;
    rep_hit = 1'b0;
    if (!down_lvl) begin
      rep_d = 8'd0;
    end else if (vblank_start) begin
      if (rep_q == 8'(REPEAT_FRAMES - 1)) begin
        rep_hit = 1'b1;
        rep_d   = 8'd0;
      end else begin
        rep_d = rep_q + 8'd1;
      end
    end
  end

  always_ff @(posedge vclk) begin
    if (rst) rep_q <= 8'd0;
    else     rep_q <= rep_d;
  end
`else
  logic unused_down_lvl;
  assign unused_down_lvl = down_lvl;
  assign rep_hit         = 1'b0;
`endif

  assign accept  = (state_q == StIssue) && cmd.cmd_ready;
  assign set_req = {down_p | rep_hit, right_p, left_p, frame & ~frz};
  assign clr_req = accept ? grant_q : 4'b0000;
  // Set wins over clear, so a request arriving during its own accept is kept.
  assign pend_d  = (pend_q & ~clr_req) | set_req;
  assign bump    = set_req & pend_q & ~clr_req;

  always_comb begin
    bump_cnt = 3'(bump[0]) + 3'(bump[1]) + 3'(bump[2]) + 3'(bump[3]);
    coal_sum = {1'b0, coal_q} + 9'(bump_cnt);
    coal_d   = coal_sum[8] ? 8'hff : coal_sum[7:0];
  end

  // Round robin over left/right/down, starting just after the last granted one.
  always_comb begin
    int unsigned idx;
    rr_any  = 1'b0;
    rr_pick = rr_last_q;
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(rr_last_q) + k) % 3;
      if (!rr_any && pend_q[idx+1]) begin
        rr_any  = 1'b1;
        rr_pick = 2'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    hold_d    = hold_q;
    unique case (state_q)
      StIdle: begin
        if ((|pend_q) && in_vblank && !frz && (budget_q != 3'd0)) state_d = StArb;
      end
      StArb: begin
        state_d = StIssue;
        if (pend_q[BitG]) begin
          // Gravity absorbs a pending soft drop into the same command.
          op_d    = 2'b00;
          grant_d = {pend_q[BitD], 2'b00, 1'b1};
        end else if (rr_any) begin
          op_d      = rr_pick + 2'd1;
          grant_d   = 4'b0010 << rr_pick;
          rr_last_d = rr_pick;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (cmd.cmd_ready) begin
          state_d = StHoldoff;
          hold_d  = 4'd0;
        end
      end
      StHoldoff: begin
        if (hold_q == 4'(HOLDOFF_CYC - 1)) state_d = StIdle;
        else                               hold_d  = hold_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    budget_d = budget_q;
    if (vblank_start)                      budget_d = 3'(CMDS_PER_FRAME);
    else if (accept && budget_q != 3'd0)   budget_d = budget_q - 3'd1;
  end

  always_ff @(posedge vclk) begin
    if (rst) begin
      state_q   <= StIdle;
      pend_q    <= 4'b0000;
      grant_q   <= 4'b0000;
      op_q      <= 2'b00;
      rr_last_q <= 2'd2;
      budget_q  <= 3'd0;
      hold_q    <= 4'd0;
      coal_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      grant_q   <= grant_d;
      op_q      <= op_d;
      rr_last_q <= rr_last_d;
      budget_q  <= budget_d;
      hold_q    <= hold_d;
      coal_q    <= coal_d;
    end
  end

  assign cmd.cmd_valid = (state_q == StIssue);
  assign cmd.cmd_op    = op_q;
  assign coalesced     = coal_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: table of request sets plus multi-cycle corner sequences.
module tb_move_scheduler;

  localparam int unsigned HOLD = 4;

  logic vclk = 1'b0;
  logic rst, frz, frame, vblank_start, in_vblank, left_p, right_p, down_p, down_lvl;
  logic [7:0] coalesced;
  int checks = 0;
  int errors = 0;
  logic [1:0] acc_q[$];

  move_scheduler_if bus ();

  move_scheduler #(
    .CMDS_PER_FRAME(2),
    .HOLDOFF_CYC   (HOLD),
    .REPEAT_FRAMES (6)
  ) dut (
    .vclk        (vclk),
    .rst         (rst),
    .frz         (frz),
    .frame       (frame),
    .vblank_start(vblank_start),
    .in_vblank   (in_vblank),
    .left_p      (left_p),
    .right_p     (right_p),
    .down_p      (down_p),
    .down_lvl    (down_lvl),
    .cmd         (bus.master),
    .coalesced   (coalesced)
  );

  always #10 vclk = ~vclk;

  // Accepted commands, sampled mid-cycle before the accepting edge.
  always @(negedge vclk) begin
    if (!rst && bus.cmd_valid && bus.cmd_ready) acc_q.push_back(bus.cmd_op);
  end

  typedef struct {
    logic g, l, r, d;
    int n1; logic [1:0] a0, a1;
    int n2; logic [1:0] b0, b1;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge vclk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; frz = 1'b0; frame = 1'b0; vblank_start = 1'b0; in_vblank = 1'b0;
    left_p = 1'b0; right_p = 1'b0; down_p = 1'b0; down_lvl = 1'b0;
    bus.cmd_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    acc_q.delete();
  endtask

  task automatic run_window(input int len, input int gap);
    vblank_start = 1'b1; in_vblank = 1'b1;
    tick();
    vblank_start = 1'b0;
    repeat (len - 1) tick();
    in_vblank = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic int acc_at(input int i);
    return (i < acc_q.size()) ? int'(acc_q[i]) : -1;
  endfunction

  initial begin
    int lat, gap, bad, n;
    //         g  l  r  d  n1 a0     a1     n2 b0     b1
    vecs[0] = '{1, 1, 1, 1, 2, 2'd0, 2'd1, 1, 2'd2, 2'd0};
    vecs[1] = '{0, 1, 0, 0, 1, 2'd1, 2'd0, 0, 2'd0, 2'd0};
    vecs[2] = '{0, 1, 1, 0, 2, 2'd1, 2'd2, 0, 2'd0, 2'd0};
    vecs[3] = '{0, 0, 1, 1, 2, 2'd2, 2'd3, 0, 2'd0, 2'd0};
    vecs[4] = '{1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 2'd0, 2'd0};
    vecs[5] = '{1, 0, 0, 1, 1, 2'd0, 2'd0, 0, 2'd0, 2'd0};
    vecs[6] = '{0, 1, 1, 1, 2, 2'd1, 2'd2, 1, 2'd3, 2'd0};
    vecs[7] = '{1, 0, 1, 0, 2, 2'd0, 2'd2, 0, 2'd0, 2'd0};

    // Reset values and a long quiet run with blanking windows but no requests.
    do_reset();
    check("rst_valid", int'(bus.cmd_valid), 0);
    check("rst_op", int'(bus.cmd_op), 0);
    check("rst_coal", int'(coalesced), 0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      vblank_start = (i % 100 == 0);
      in_vblank    = (i % 100) < 30;
      tick();
      if (bus.cmd_valid) bad++;
    end
    in_vblank = 1'b0;
    check("idle_valid_cycles", bad, 0);
    check("idle_coal", int'(coalesced), 0);

    // Table: requests latched outside blanking, issued over two windows.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      if (vecs[v].g) begin frame   = 1'b1; tick(); frame   = 1'b0; end
      if (vecs[v].l) begin left_p  = 1'b1; tick(); left_p  = 1'b0; end
      if (vecs[v].r) begin right_p = 1'b1; tick(); right_p = 1'b0; end
      if (vecs[v].d) begin down_p  = 1'b1; tick(); down_p  = 1'b0; end
      tick();
      run_window(40, 20);
      check($sformatf("v%0d_w1_count", v), acc_q.size(), vecs[v].n1);
      for (int i = 0; i < vecs[v].n1; i++)
        check($sformatf("v%0d_w1_op%0d", v, i), acc_at(i),
              int'(i == 0 ? vecs[v].a0 : vecs[v].a1));
      acc_q.delete();
      run_window(40, 20);
      check($sformatf("v%0d_w2_count", v), acc_q.size(), vecs[v].n2);
      for (int i = 0; i < vecs[v].n2; i++)
        check($sformatf("v%0d_w2_op%0d", v, i), acc_at(i),
              int'(i == 0 ? vecs[v].b0 : vecs[v].b1));
      check($sformatf("v%0d_coal", v), int'(coalesced), 0);
    end

    // Latency from a request inside the window, one-cycle valid, holdoff spacing.
    do_reset();
    vblank_start = 1'b1; in_vblank = 1'b1;
    tick();
    vblank_start = 1'b0;
    repeat (5) tick();
    left_p = 1'b1;
    tick();
    left_p = 1'b0;
    lat = 0;
    while (!bus.cmd_valid && lat < 20) begin tick(); lat++; end
    check("lat_cycles", lat, 2);
    check("lat_op", int'(bus.cmd_op), 1);
    right_p = 1'b1;
    tick();
    right_p = 1'b0;
    check("lat_valid_one_cycle", int'(bus.cmd_valid), 0);
    gap = 1;
    while (!bus.cmd_valid && gap < 30) begin tick(); gap++; end
    checks++;
    if (gap < HOLD + 2 || gap >= 30) begin
      errors++;
      $display("FAIL holdoff_gap: got %0d expected >= %0d and issued", gap, HOLD + 2);
    end
    check("holdoff_second_op", int'(bus.cmd_op), 2);
    in_vblank = 1'b0;
    repeat (10) tick();

    // Stall across the end of blanking, then the remaining budget of one.
    do_reset();
    left_p = 1'b1; tick(); left_p = 1'b0;
    right_p = 1'b1; tick(); right_p = 1'b0;
    bus.cmd_ready = 1'b0;
    vblank_start = 1'b1; in_vblank = 1'b1;
    tick();
    vblank_start = 1'b0;
    n = 0;
    while (!bus.cmd_valid && n < 20) begin tick(); n++; end
    in_vblank = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.cmd_valid || bus.cmd_op != 2'd1) bad++;
      tick();
    end
    check("stall_unstable_cycles", bad, 0);
    check("stall_no_accept", acc_q.size(), 0);
    bus.cmd_ready = 1'b1;
    repeat (10) tick();
    check("stall_single_accept", acc_q.size(), 1);
    check("stall_accept_op", acc_at(0), 1);
    in_vblank = 1'b1;
    repeat (60) tick();
    in_vblank = 1'b0;
    check("budget_left_count", acc_q.size(), 2);
    check("budget_left_op", acc_at(1), 2);

    // Freeze: coalescing saturates, gravity ignored, one LEFT once unfrozen.
    do_reset();
    frz = 1'b1;
    vblank_start = 1'b1; in_vblank = 1'b1;
    tick();
    vblank_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      left_p = 1'b1; tick(); left_p = 1'b0; tick();
    end
    frame = 1'b1; tick(); frame = 1'b0; tick();
    check("frz_coal_sat", int'(coalesced), 255);
    check("frz_no_issue", acc_q.size(), 0);
    frz = 1'b0;
    repeat (30) tick();
    in_vblank = 1'b0;
    repeat (5) tick();
    check("frz_resume_count", acc_q.size(), 1);
    check("frz_resume_op", acc_at(0), 1);
    run_window(40, 10);
    check("frz_nothing_more", acc_q.size(), 1);

    // DOWN held for 13 frames.
    do_reset();
    down_lvl = 1'b1;
    for (int f = 0; f < 13; f++) run_window(30, 10);
    down_lvl = 1'b0;
    n = 0;
    for (int i = 0; i < acc_q.size(); i++) if (acc_q[i] == 2'd3) n++;
`ifdef SOFT_DROP_REPEAT_EN
    check("repeat_soft_downs", n, 2);
`else
    check("repeat_soft_downs", n, 0);
`endif
    check("repeat_total_cmds", acc_q.size(), n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
